rf_wb_arbiter: RTL
==================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port clr, input, 1, reset; synchronous and active-low (clears state on the clk edge where clr=0).
REQ-003 SHALL have port wb_we / wb_rw / wb_rd, inputs, 1/5/32, pipeline writeback request; it cannot be back-pressured except via wb_stall.
REQ-004 SHALL have port md_valid / md_rw / md_rd, inputs, 1/5/32, mul/div result offer.
REQ-005 SHALL have port md_ready, output, 1, result accepted when md_valid&&md_ready.
REQ-006 SHALL have port md_issue / md_issue_rw, inputs, 1/5, mul/div issued with destination register.
REQ-007 SHALL have port hz_ra / hz_rb / hz_rw, inputs, 5 each, decode-stage source and destination registers.
REQ-008 SHALL have port hazard, output, 1, combinational: busy[hz_ra]|busy[hz_rb]|busy[hz_rw].
REQ-009 SHALL have port wb_stall, output, 1, registered; pipeline holds its writeback this cycle.
REQ-010 SHALL have port rf_we / rf_rw / rf_rd, outputs, 1/5/32, registered drive of the RF write port.
REQ-011 SHALL have parameter DEPTH, default 2, mul/div result buffer entries.
REQ-012 SHALL have parameter STARVE_LIMIT, default 4, wait cycles before forcing a stall.

Function
REQ-013 SHALL give a one-cycle latency: the source selected in cycle N appears on rf_* in cycle N+1.
REQ-014 SHALL give the pipeline absolute priority: when wb_we=1, wb_rw!=0 and wb_stall=0, rf_* in N+1 = {1, wb_rw, wb_rd}.
REQ-015 SHALL ignore wb_we while wb_stall=1; the pipeline re-presents the write afterwards.
REQ-016 SHALL buffer accepted md results in an in-order FIFO of DEPTH entries {rw, rd, kill}.
REQ-017 SHALL drive md_ready = (count<DEPTH); it stays low when full even if the FIFO drains that cycle.
REQ-018 SHALL consume an md result with md_rw=0 when accepted, but not store it.
REQ-019 SHALL drain the head when the port is free (no pipeline write and no wb_stall) or when wb_stall=1; it then writes rf_* = {1, rw, rd}.
REQ-020 SHALL drain a killed head in any cycle, including cycles with a pipeline write, with no RF write for it.
REQ-021 SHALL set kill on every non-killed FIFO entry whose rw equals wb_rw during a pipeline write, because the later write wins.
REQ-022 SHALL keep the push path from bypassing: an entry pushed in cycle N drains no earlier than cycle N+1 (RF write at N+2).
REQ-023 SHALL make the push/drain operation legal in the same cycle; count changes net.
REQ-024 SHALL use an age counter that increments each cycle a non-killed head waits undrained and clears on drain.
REQ-025 SHALL register wb_stall=1 for exactly one cycle when age reaches STARVE_LIMIT, and SHALL clear age afterwards.
REQ-026 SHALL set busy[md_issue_rw] on md_issue (ignored for r0) and SHALL clear it when that register's entry drains, killed or not.
REQ-027 SHALL keep busy[0] at 0.
REQ-028 SHALL treat md_issue to an already-busy register as a protocol violation; busy stays set.
REQ-029 SHALL apply the clear first when md_issue and a drain hit the same register in the same cycle, then the set, so the register ends busy.
REQ-030 SHALL never write r0: rf_we=0 whenever the selected rw=0.

Reset
REQ-031 SHALL, while clr=0, set rf_we=0, rf_rw=0, rf_rd=0, wb_stall=0, FIFO empty (count 0, pointers 0), age 0, busy all 0.
REQ-032 SHALL drive md_ready=1 in the first cycle after reset.
REQ-033 SHALL let a reset mid-operation discard buffered results; no RF write follows.

Structure
REQ-034 SHALL place the RF address width (5), data width (32) and the FIFO entry struct/constants in a shared CPU package.
REQ-035 SHALL implement the buffer as one sub-module, md_fifo (push/pop/kill-match, count output).
REQ-036 SHALL keep the arbiter, age counter and busy scoreboard in rf_wb_arbiter.

Verification
REQ-037 SHALL cover: wb write r4=0x04 with FIFO empty -> next cycle rf_we=1, rf_rw=4, rf_rd=0x04.
REQ-038 SHALL cover: md_issue r8, then md result r8=0x08 while wb idle -> RF write r8=0x08 two cycles after acceptance; hazard for hz_ra=8 high until the drain, then low.
REQ-039 SHALL cover: two md results r16=0x10, r17=0x11 with continuous wb writes to r5 -> md_ready=0 after 2 pushes; wb_stall pulses after 4 waits; r16 and then r17 written in order.
REQ-040 SHALL cover: buffered md r18=0x12, then wb write r18=0x99 -> r18 entry killed; only 0x99 reaches the RF; busy[18] clears.
REQ-041 SHALL cover: md result with md_rw=0 and wb write to r0 -> rf_we stays 0.
REQ-042 SHALL cover: clr=0 with 2 entries buffered -> all outputs 0, md_ready=1 next cycle, no later write of buffered data.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared CPU register-file widths and mul/div buffer entry type
package rf_wb_arbiter_pkg;

  localparam int RF_AW   = 5;
  localparam int RF_DW   = 32;
  localparam int RF_NREG = 1 << RF_AW;

  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [RF_DW-1:0] rf_data_t;

  // One buffered mul/div result; kill marks it as overwritten by a later pipeline write
  typedef struct packed {
    rf_addr_t rw;
    rf_data_t rd;
    logic     kill;
  } md_entry_t;

  localparam md_entry_t MD_ENTRY_NULL = '{rw: '0, rd: '0, kill: 1'b0};

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - writeback, mul/div, hazard and RF-port signals of the arbiter
interface rf_wb_arbiter_if;
  import rf_wb_arbiter_pkg::*;

  logic     wb_we;
  rf_addr_t wb_rw;
  rf_data_t wb_rd;

  logic     md_valid;
  rf_addr_t md_rw;
  rf_data_t md_rd;
  logic     md_ready;

  logic     md_issue;
  rf_addr_t md_issue_rw;

  rf_addr_t hz_ra;
  rf_addr_t hz_rb;
  rf_addr_t hz_rw;
  logic     hazard;

  logic     wb_stall;

  logic     rf_we;
  rf_addr_t rf_rw;
  rf_data_t rf_rd;

  // Pipeline / mul-div unit side
  modport master (
    output wb_we, wb_rw, wb_rd, md_valid, md_rw, md_rd, md_issue, md_issue_rw,
           hz_ra, hz_rb, hz_rw,
    input  md_ready, hazard, wb_stall, rf_we, rf_rw, rf_rd
  );

  // Arbiter side
  modport slave (
    input  wb_we, wb_rw, wb_rd, md_valid, md_rw, md_rd, md_issue, md_issue_rw,
           hz_ra, hz_rb, hz_rw,
    output md_ready, hazard, wb_stall, rf_we, rf_rw, rf_rd
  );

endinterface

// File: rtl/rf_wb_arbiter_md_fifo.sv
// rtl/rf_wb_arbiter_md_fifo.sv - in-order mul/div result buffer with destination kill-match
module md_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push_i,
  input  rf_addr_t      push_rw_i,
  input  rf_data_t      push_rd_i,
  input  logic          pop_i,
  input  logic          kill_i,
  input  rf_addr_t      kill_rw_i,
  output md_entry_t     head_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  md_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy next state; a simultaneous push and pop leave count unchanged
  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push_i && !pop_i) count_d = count_q + 1'b1;
    if (!push_i && pop_i) count_d = count_q - 1'b1;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (!clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage: matching entries are killed first, then the new entry lands in its (free) slot
  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= MD_ENTRY_NULL;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_i && (mem_q[i].rw == kill_rw_i)) mem_q[i].kill <= 1'b1;
      end
      if (push_i) mem_q[wr_ptr_q] <= '{rw: push_rw_i, rd: push_rd_i, kill: 1'b0};
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port arbiter between pipeline writeback and mul/div results
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           clr,
  rf_wb_arbiter_if.slave bus
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int AGW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0]      count;
  md_entry_t          head;
  logic               head_valid;
  logic               pw_write;
  logic               drain;
  logic               head_wait;
  logic               md_ready;
  logic               push;

  logic               rf_we_q, rf_we_d;
  rf_addr_t           rf_rw_q, rf_rw_d;
  rf_data_t           rf_rd_q, rf_rd_d;
  logic               wb_stall_q, wb_stall_d;
  logic [AGW-1:0]     age_q, age_d;
  logic [RF_NREG-1:0] busy_q, busy_d;

  // A pipeline write owns the port only when it targets a real register and is not being stalled
  assign head_valid = (count != '0);
  assign pw_write   = bus.wb_we && !wb_stall_q && (bus.wb_rw != '0);
  assign drain      = head_valid && (head.kill || !pw_write);
  assign head_wait  = head_valid && !head.kill && pw_write;

  // Ready looks only at registered occupancy, so a full buffer refuses even while draining
  assign md_ready = (count < CW'(DEPTH));
  assign push     = bus.md_valid && md_ready && (bus.md_rw != '0);

  md_fifo #(.DEPTH(DEPTH)) u_md_fifo (
    .clk       (clk),
    .clr       (clr),
    .push_i    (push),
    .push_rw_i (bus.md_rw),
    .push_rd_i (bus.md_rd),
    .pop_i     (drain),
    .kill_i    (pw_write),
    .kill_rw_i (bus.wb_rw),
    .head_o    (head),
    .count_o   (count)
  );

  // RF port selection: pipeline first, then a live buffered result; r0 is never written
  always_comb begin
    rf_we_d = 1'b0;
    rf_rw_d = '0;
    rf_rd_d = '0;
    if (pw_write) begin
      rf_we_d = 1'b1;
      rf_rw_d = bus.wb_rw;
      rf_rd_d = bus.wb_rd;
    end else if (drain && !head.kill && (head.rw != '0)) begin
      rf_we_d = 1'b1;
      rf_rw_d = head.rw;
      rf_rd_d = head.rd;
    end
  end

  // Starvation guard: after STARVE_LIMIT blocked cycles the pipeline is held for one cycle
  always_comb begin
    age_d      = '0;
    wb_stall_d = 1'b0;
    if (head_wait) begin
      if (age_q == AGW'(STARVE_LIMIT - 1)) begin
        wb_stall_d = 1'b1;
      end else begin
        age_d = age_q + 1'b1;
      end
    end
  end

  // Busy scoreboard: clear on drain before set on issue, so a same-cycle hit stays busy
  always_comb begin
    busy_d = busy_q;
    if (drain) busy_d[head.rw] = 1'b0;
    if (bus.md_issue) busy_d[bus.md_issue_rw] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Arbiter state registers
  always_ff @(posedge clk) begin
    if (!clr) begin
      rf_we_q    <= 1'b0;
      rf_rw_q    <= '0;
      rf_rd_q    <= '0;
      wb_stall_q <= 1'b0;
      age_q      <= '0;
      busy_q     <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_rw_q    <= rf_rw_d;
      rf_rd_q    <= rf_rd_d;
      wb_stall_q <= wb_stall_d;
      age_q      <= age_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.md_ready = md_ready;
  assign bus.wb_stall = wb_stall_q;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_rw    = rf_rw_q;
  assign bus.rf_rd    = rf_rd_q;
  assign bus.hazard   = busy_q[bus.hz_ra] | busy_q[bus.hz_rb] | busy_q[bus.hz_rw];

endmodule
